gpc_mem_arbiter: RTL and testbench

Two-master arbiter for the GPC 16-bit-address / 8-bit-data memory bus. It sits between the `gpc_cpu` bus port (master 0) and a second bus master (master 1, e.g. a program loader or DMA engine), and drives a single shared memory port. It uses registered grants, a one-cycle turnaround on every owner change, round-robin fairness under contention and an optional burst limit.

---
 rtl/gpc_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_gpc_mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gpc_mem_arbiter.sv
// Two-master arbiter for the GPC memory bus: registered grants, one-cycle turnaround, round-robin.
// Define ARB_BURST_LIMIT_EN to preempt an owner after MAX_BURST transfers while the other master waits.
module gpc_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic              mem_oe,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  // state | meaning
  // IDLE  | bus free, no grant
  // GNT0  | master 0 owns the bus
  // GNT1  | master 1 owns the bus
  // TURN  | one dead cycle between owners, waiting master is ~last
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, TURN = 2'd3} state_t;

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end

  state_t state, state_nx;
  logic   last, last_nx;
  logic   burst_done;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             entering_gnt;

  assign xfer         = ((state == GNT0) && m0_req) || ((state == GNT1) && m1_req);
  assign entering_gnt = ((state_nx == GNT0) && (state != GNT0)) ||
                        ((state_nx == GNT1) && (state != GNT1));
  assign burst_done   = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (entering_gnt) begin
      cnt <= '0;
    end else if (xfer && !burst_done) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  // last resets to master 1 so master 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nx = last ? GNT0 : GNT1;
        else if (m0_req)      state_nx = GNT0;
        else if (m1_req)      state_nx = GNT1;
      end
      GNT0: begin
        if (!m0_req)                 state_nx = m1_req ? TURN : IDLE;
        else if (burst_done && m1_req) state_nx = TURN;
      end
      GNT1: begin
        if (!m1_req)                 state_nx = m0_req ? TURN : IDLE;
        else if (burst_done && m0_req) state_nx = TURN;
      end
      TURN: begin
        if (last) state_nx = m0_req ? GNT0 : IDLE;
        else      state_nx = m1_req ? GNT1 : IDLE;
      end
      default: state_nx = IDLE;
    endcase

    last_nx = last;
    if ((state_nx == GNT0) && (state != GNT0)) last_nx = 1'b0;
    if ((state_nx == GNT1) && (state != GNT1)) last_nx = 1'b1;
  end

  // bus controls are qualified by req so a release idles the bus in its last granted cycle
  always_comb begin
    m0_gnt    = (state == GNT0);
    m1_gnt    = (state == GNT1);
    owner     = {m1_gnt, m0_gnt};
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rw    = 1'b0;
    if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_rw    = m0_req & m0_rw;
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_rw    = m1_req & m1_rw;
    end
    mem_oe = mem_rw;
  end

  assign m_rdata = mem_rdata;

endmodule

// File: tb/tb_gpc_mem_arbiter.sv
// Scoreboard bench for gpc_mem_arbiter: directed expectations queued by stimulus, checked at negedge.
module tb_gpc_mem_arbiter;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic [1:0]  own;
    logic [15:0] addr;
    logic        rw;
    logic        oe;
    logic [7:0]  wd;
    logic [7:0]  rd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata, mem_rdata;
  logic        m0_gnt, m1_gnt, mem_rw, mem_oe;
  logic [7:0]  m_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [1:0]  owner;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    done     = 1'b0;

  gpc_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m_rdata(m_rdata), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  // queue an expectation for the next falling edge, then resume just after it
  task automatic check(input string nm, input logic g0, input logic g1, input logic [1:0] own,
                       input logic [15:0] addr, input logic rw, input logic oe,
                       input logic [7:0] wd, input logic [7:0] rd);
    obs_t e;
    e = '{g0: g0, g1: g1, own: own, addr: addr, rw: rw, oe: oe, wd: wd, rd: rd};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // monitor: scoreboard pops plus grant exclusivity and handover-gap invariants
  initial begin : monitor
    obs_t       act, e;
    string      nm;
    logic [1:0] cur;
    logic [1:0] last_own = 2'b00;
    int         gap = 0;
    forever begin
      @(negedge clk);
      act = '{g0: m0_gnt, g1: m1_gnt, own: owner, addr: mem_addr, rw: mem_rw,
              oe: mem_oe, wd: mem_wdata, rd: m_rdata};
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got g0=%b g1=%b own=%b addr=%h rw=%b oe=%b wd=%h rd=%h, want g0=%b g1=%b own=%b addr=%h rw=%b oe=%b wd=%h rd=%h",
                      nm, act.g0, act.g1, act.own, act.addr, act.rw, act.oe, act.wd, act.rd,
                      e.g0, e.g1, e.own, e.addr, e.rw, e.oe, e.wd, e.rd);
      end
      n_checks++;
      if (!(m0_gnt === 1'b1 && m1_gnt === 1'b1)) n_pass++;
      else $display("FAIL grant_excl at %0t: got m0_gnt=%b m1_gnt=%b, want not both high", $time, m0_gnt, m1_gnt);
      cur = {m1_gnt, m0_gnt};
      if (cur == 2'b00) begin
        gap++;
      end else begin
        if (last_own != 2'b00 && cur != last_own) begin
          n_checks++;
          if (gap >= 1) n_pass++;
          else $display("FAIL handover_gap at %0t: got %0d idle cycles, want at least 1", $time, gap);
        end
        last_own = cur;
        gap = 0;
      end
      if (done) begin
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    m0_req = 1'b0; m0_addr = 16'h1234; m0_rw = 1'b1; m0_wdata = 8'h11;
    m1_req = 1'b0; m1_addr = 16'h8010; m1_rw = 1'b1; m1_wdata = 8'hA5;
    mem_rdata = 8'h5A;
    check("reset", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h5A);
    check("reset_hold", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h5A);

    rst_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    check("first_gnt", 1, 0, 2'b01, 16'h1234, 1, 1, 8'h11, 8'h5A);
`ifdef ARB_BURST_LIMIT_EN
    for (int i = 0; i < 7; i++)
      check("burst_hold", 1, 0, 2'b01, 16'h1234, 1, 1, 8'h11, 8'h5A);
    check("burst_turn", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h5A);
    check("burst_m1", 0, 1, 2'b10, 16'h8010, 1, 1, 8'hA5, 8'h5A);
    m0_req = 1'b0;
`else
    for (int i = 0; i < 19; i++)
      check("no_preempt_hold", 1, 0, 2'b01, 16'h1234, 1, 1, 8'h11, 8'h5A);
    m0_req = 1'b0;
    check("rel_turn", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h5A);
    check("rel_m1", 0, 1, 2'b10, 16'h8010, 1, 1, 8'hA5, 8'h5A);
`endif

    m1_rw = 1'b0; mem_rdata = 8'h3C;
    check("m1_read", 0, 1, 2'b10, 16'h8010, 0, 0, 8'hA5, 8'h3C);

    @(posedge clk); #1;
    m1_req = 1'b0; m1_rw = 1'b1;
    check("m1_rel_comb", 0, 1, 2'b10, 16'h8010, 0, 0, 8'hA5, 8'h3C);
    check("m1_rel_idle", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h3C);

    m0_req = 1'b1;
    check("m0_alone", 1, 0, 2'b01, 16'h1234, 1, 1, 8'h11, 8'h3C);
    m0_req = 1'b0;
    check("m0_rel_idle", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h3C);

    m0_req = 1'b1; m1_req = 1'b1;
    check("rr_m1", 0, 1, 2'b10, 16'h8010, 1, 1, 8'hA5, 8'h3C);
    check("m1_write", 0, 1, 2'b10, 16'h8010, 1, 1, 8'hA5, 8'h3C);

    @(posedge clk); #1;
    rst_n = 1'b0;
    check("rst_async", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h3C);
    rst_n = 1'b1;
    check("post_rst_m0", 1, 0, 2'b01, 16'h1234, 1, 1, 8'h11, 8'h3C);
    m0_req = 1'b0; m1_req = 1'b0;
    check("idle_again", 0, 0, 2'b00, 16'h0000, 0, 0, 8'h00, 8'h3C);

    for (int i = 0; i < 100; i++) begin
      m0_req = 1'($urandom_range(0, 1));
      m1_req = 1'($urandom_range(0, 1));
      m0_rw  = 1'($urandom_range(0, 1));
      m1_rw  = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    done = 1'b1;
  end

endmodule
